// File: rtl/egk_binary_decode.sv
// egk_binary_decode: serial order-K Exp-Golomb decoder.
// Consumes one bin per handshake, MSB first. A zero-run prefix is terminated
// by '1' and followed by an lN+K bit suffix. The decoder reconstructs the
// value N and the number of bins the code occupied.
// Optional feature macro: EGK_DEC_ABORT_EN adds the abort_i input, which
// drops any in-flight code or pending result.
module egk_binary_decode #(
  parameter int VALUE_WIDTH = 8,
  parameter int BIN_WIDTH   = 16,
  parameter int K           = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bin_valid_i,
  input  logic                   bin_i,
  output logic                   bin_ready_o,
  output logic                   valid_o,
  input  logic                   value_ready_i,
  output logic [VALUE_WIDTH-1:0] value_o,
  output logic [BIN_WIDTH-1:0]   bin_length_o,
  output logic                   error_o
`ifdef EGK_DEC_ABORT_EN
  ,
  input  logic                   abort_i
`endif
);

  localparam int LW = $clog2(VALUE_WIDTH + 1);
  localparam logic [LW-1:0] K_L    = LW'(K);
  localparam logic [LW-1:0] LN_MAX = LW'(VALUE_WIDTH - K - 1);

  typedef enum logic [1:0] {
    ST_PREFIX,
    ST_SUFFIX,
    ST_DONE
  } state_t;

  state_t                 state_q, state_n;
  logic [LW-1:0]          ln_q, ln_n;
  logic [LW-1:0]          rem_q, rem_n;
  logic [VALUE_WIDTH-1:0] suf_q, suf_n;
  logic [BIN_WIDTH-1:0]   cnt_q, cnt_n;
  logic [VALUE_WIDTH-1:0] val_q, val_n;
  logic [BIN_WIDTH-1:0]   len_q, len_n;
  logic                   err_q, err_n;

  logic                   accept;
  logic [BIN_WIDTH-1:0]   cnt_inc;
  logic [LW-1:0]          rem_load;
  logic [VALUE_WIDTH-1:0] suf_shift;
  logic [VALUE_WIDTH-1:0] prefix_ones;

  assign bin_ready_o  = (state_q != ST_DONE);
  assign valid_o      = (state_q == ST_DONE);
  assign value_o      = val_q;
  assign bin_length_o = len_q;
  assign error_o      = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_PREFIX;
    else        state_q <= state_n;
  end

  // Datapath registers: prefix run, remaining suffix bins, suffix, length, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ln_q  <= '0;
      rem_q <= '0;
      suf_q <= '0;
      cnt_q <= '0;
      val_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      ln_q  <= ln_n;
      rem_q <= rem_n;
      suf_q <= suf_n;
      cnt_q <= cnt_n;
      val_q <= val_n;
      len_q <= len_n;
      err_q <= err_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state_q;
    ln_n    = ln_q;
    rem_n   = rem_q;
    suf_n   = suf_q;
    cnt_n   = cnt_q;
    val_n   = val_q;
    len_n   = len_q;
    err_n   = err_q;

    accept      = bin_valid_i && (state_q != ST_DONE);
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + BIN_WIDTH'(1);
    rem_load    = ln_q + K_L;
    suf_shift   = (suf_q << 1) | VALUE_WIDTH'(bin_i);
    // The full value always fits VALUE_WIDTH because lN <= LN_MAX, so the
    // extra guard bit of the reference formula is never needed.
    prefix_ones = ((VALUE_WIDTH'(1) << ln_q) - VALUE_WIDTH'(1)) << K;

    case (state_q)
      ST_PREFIX: begin
        if (accept) begin
          cnt_n = cnt_inc;
          if (!bin_i) begin
            if (ln_q == LN_MAX) begin
              state_n = ST_DONE;
              val_n   = '0;
              len_n   = cnt_inc;
              err_n   = 1'b1;
            end else begin
              ln_n = ln_q + LW'(1);
            end
          end else begin
            rem_n = rem_load;
            suf_n = '0;
            if (rem_load == '0) begin
              state_n = ST_DONE;
              val_n   = '0;
              len_n   = cnt_inc;
              err_n   = 1'b0;
            end else begin
              state_n = ST_SUFFIX;
            end
          end
        end
      end
      ST_SUFFIX: begin
        if (accept) begin
          cnt_n = cnt_inc;
          suf_n = suf_shift;
          rem_n = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_n = ST_DONE;
            val_n   = prefix_ones + suf_shift;
            len_n   = cnt_inc;
            err_n   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (value_ready_i) begin
          state_n = ST_PREFIX;
          ln_n    = '0;
          rem_n   = '0;
          suf_n   = '0;
          cnt_n   = '0;
          val_n   = '0;
          len_n   = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = ST_PREFIX;
    endcase

`ifdef EGK_DEC_ABORT_EN
    if (abort_i) begin
      state_n = ST_PREFIX;
      ln_n    = '0;
      rem_n   = '0;
      suf_n   = '0;
      cnt_n   = '0;
      val_n   = '0;
      len_n   = '0;
      err_n   = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_egk_binary_decode.sv
// tb_egk_binary_decode: directed vectors on two decoder instances (K=0, K=2).
// Expected results are queued when a code is issued; a negedge monitor
// compares them when the decoder presents valid_o.
module tb_egk_binary_decode;

  typedef struct {
    logic [7:0]  v;
    logic [15:0] l;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv [2];
  logic        bn [2];
  logic        vr [2];
  logic        br [2];
  logic        vo [2];
  logic [7:0]  val [2];
  logic [15:0] len [2];
  logic        err [2];
`ifdef EGK_DEC_ABORT_EN
  logic        ab [2];
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  egk_binary_decode #(.VALUE_WIDTH(8), .BIN_WIDTH(16), .K(0)) u_k0 (
    .clk(clk), .rst_n(rst_n), .bin_valid_i(bv[0]), .bin_i(bn[0]),
    .bin_ready_o(br[0]), .valid_o(vo[0]), .value_ready_i(vr[0]),
    .value_o(val[0]), .bin_length_o(len[0]), .error_o(err[0])
`ifdef EGK_DEC_ABORT_EN
    , .abort_i(ab[0])
`endif
  );

  egk_binary_decode #(.VALUE_WIDTH(8), .BIN_WIDTH(16), .K(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .bin_valid_i(bv[1]), .bin_i(bn[1]),
    .bin_ready_o(br[1]), .valid_o(vo[1]), .value_ready_i(vr[1]),
    .value_o(val[1]), .bin_length_o(len[1]), .error_o(err[1])
`ifdef EGK_DEC_ABORT_EN
    , .abort_i(ab[1])
`endif
  );

  task automatic mon(input int d, input logic v, input logic r, input logic [7:0] vv,
                     input logic [15:0] ll, input logic ee, input logic rd);
    exp_t x;
    total++;
    if (r !== !v) begin
      bad++;
      $display("FAIL ready dut%0d: bin_ready_o=%b with valid_o=%b, required %b", d, r, v, !v);
    end
    total++;
    if (v === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        bad++;
        $display("FAIL unexpected dut%0d: valid_o=1 value=%0d len=%0d err=%b, no result required",
                 d, vv, ll, ee);
      end else begin
        if (d == 0) x = q0[0];
        else        x = q1[0];
        if (vv !== x.v || ll !== x.l || ee !== x.e) begin
          bad++;
          $display("FAIL result dut%0d: value=%0d len=%0d err=%b, required value=%0d len=%0d err=%b",
                   d, vv, ll, ee, x.v, x.l, x.e);
        end
        if (rd === 1'b1) begin
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end else begin
      if (vv !== 8'd0 || ll !== 16'd0 || ee !== 1'b0) begin
        bad++;
        $display("FAIL idle dut%0d: value=%0d len=%0d err=%b, required all zero", d, vv, ll, ee);
      end
    end
  endtask

  // Monitor: compare presented results away from the active edge.
  always @(negedge clk) begin
    mon(0, vo[0], br[0], val[0], len[0], err[0], vr[0]);
    mon(1, vo[1], br[1], val[1], len[1], err[1], vr[1]);
  end

  task automatic expect_res(input int d, input logic [7:0] v, input logic [15:0] l, input logic e);
    exp_t x;
    x.v = v; x.l = l; x.e = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Send n bins MSB first; each bin is held until accepted.
  task automatic send(input int d, input logic [31:0] bits, input int n);
    logic rdy;
    int   waited;
    for (int i = 0; i < n; i++) begin
      bv[d] = 1'b1;
      bn[d] = bits[n-1-i];
      waited = 0;
      do begin
        @(negedge clk);
        rdy = br[d];
        @(posedge clk);
        #1;
        waited++;
      end while (!rdy && waited < 50);
      if (!rdy) begin
        bad++;
        $display("FAIL timeout dut%0d: bin %0d not accepted after %0d cycles", d, i, waited);
      end
    end
    bv[d] = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      bv[d] = 1'b0; bn[d] = 1'b0; vr[d] = 1'b1;
`ifdef EGK_DEC_ABORT_EN
      ab[d] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // K=0 basic codes
    expect_res(0, 8'd0, 16'd1, 1'b0); send(0, 32'b1, 1);
    expect_res(0, 8'd6, 16'd5, 1'b0); send(0, 32'b00111, 5);

    // K=2 codes
    expect_res(1, 8'd1, 16'd3, 1'b0); send(1, 32'b101, 3);
    expect_res(1, 8'd9, 16'd5, 1'b0); send(1, 32'b01101, 5);
    // K=2 overflow: LN_MAX=5, sixth zero errors
    expect_res(1, 8'd0, 16'd6, 1'b1); send(1, 32'b000000, 6);
    expect_res(1, 8'd0, 16'd3, 1'b0); send(1, 32'b100, 3);
    drain();

    // K=0 stall: result held 3 cycles, toggling bins must not be consumed
    vr[0] = 1'b0;
    expect_res(0, 8'd2, 16'd3, 1'b0); send(0, 32'b011, 3);
    bv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bn[0] = ~bn[0];
      @(posedge clk);
      #1;
    end
    vr[0] = 1'b1;
    bv[0] = 1'b0;
    expect_res(0, 8'd4, 16'd5, 1'b0); send(0, 32'b00101, 5);

    // K=0 overflow then recovery
    expect_res(0, 8'd0, 16'd8, 1'b1); send(0, 32'b00000000, 8);
    expect_res(0, 8'd0, 16'd1, 1'b0); send(0, 32'b1, 1);
    drain();

    // Partial code cut short by reset: nothing may be emitted
    send(0, 32'b00010, 5);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_res(0, 8'd1, 16'd3, 1'b0); send(0, 32'b010, 3);
    drain();

    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: outstanding results q0=%0d q1=%0d, required 0", q0.size(), q1.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/egk_binary_decode.md
# egk_binary_decode

Serial order-K Exp-Golomb decoder. It consumes one bin per handshake, MSB first, with a zero-run prefix terminated by '1' followed by a suffix of lN+K bits. It reconstructs the unsigned value and the total code length. It is the receive-side counterpart of the EGk binary encoder in the binarization path and is used by the entropy-decode datapath and by encoder loopback checking.

## Interface
- `VALUE_WIDTH`, 8: width of the decoded value.
- `BIN_WIDTH`, 16: width of the `bin_length_o` field.
- `K`, 0: Golomb order; legal range 0 ≤ K ≤ VALUE_WIDTH-1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `bin_valid_i`  in  1: `bin_i` is valid.
- `bin_i`  in  1: next code bin, MSB first.
- `bin_ready_o`  out  1: decoder accepts a bin this cycle.
- `valid_o`  out  1: a decoded result is presented.
- `value_ready_i`  in  1: downstream consumes the result.
- `value_o`  out  VALUE_WIDTH: decoded value N.
- `bin_length_o`  out  BIN_WIDTH: number of bins consumed for this code.
- `error_o`  out  1: prefix overflow; qualified by `valid_o`.

## Operation
- A bin is accepted when `bin_valid_i && bin_ready_o` at a rising edge.
- `bin_ready_o` is 1 in PREFIX and SUFFIX and 0 in DONE. It is decoded from registered state only.
- **PREFIX** (reset state):
  - Accepted '0' increments `lN`.
  - Accepted '1' loads `rem = lN+K` and clears `suf`.
  - If `rem == 0`, go to DONE with N=0; otherwise go to SUFFIX.
- **Overflow:** `LN_MAX = VALUE_WIDTH-K-1`. An accepted '0' while `lN == LN_MAX` goes to DONE with `error_o=1` and `value_o=0`.
- **SUFFIX:** each accepted bin does `suf = (suf<<1) | bin_i` and `rem--`. The bin that takes `rem` to 0 moves the FSM to DONE.
- **DONE:**
  - Outputs are held stable with `valid_o=1`.
  - When `value_ready_i=1`, the result is consumed; the FSM clears `lN`, `rem`, `suf` and the length counter, then returns to PREFIX.
- **Value:** `N = (((1<<lN)-1) << K) + suf`, computed in VALUE_WIDTH+1 bits. The result always fits VALUE_WIDTH given `LN_MAX`. For K=0 this is `N = (1<<lN) - 1 + suf`, the exact inverse of the encoder.
- **Length:** `bin_length_o = 2*lN + K + 1` on success, or the count of bins consumed on error. It is counted as accepted bins, saturating at 2^BIN_WIDTH-1.
- Bins presented while `bin_ready_o=0` are not consumed. The upstream source must hold them.
- `value_ready_i` is ignored outside DONE.

## Timing
- **Reset values:**
  - State = PREFIX and all counters = 0.
  - `bin_ready_o=1`, `valid_o=0`, `value_o=0`, `bin_length_o=0`, `error_o=0`.
- Reset asserted mid-code aborts it immediately. No partial result is emitted, and decoding restarts in PREFIX after deassertion.
- `valid_o` rises on the edge that accepts the terminating bin, so it is visible in the next cycle.
- A code of L bins occupies L accepting cycles plus ≥1 DONE cycle.
- Peak throughput is one code per L+1 cycles.
- `value_o`, `bin_length_o` and `error_o` are registered. They are zero whenever `valid_o=0`.
- Consumption in DONE and bin acceptance never coincide, because `bin_ready_o=0` in DONE.

## Configuration
- **`EGK_DEC_ABORT_EN` defined:**
  - An extra input `abort_i` (1 bit) exists.
  - When sampled high, it returns the FSM to PREFIX, clears all counters and drops any pending DONE result, so `valid_o=0` next cycle.
  - It has priority over a same-cycle bin acceptance (that bin is discarded) and over `value_ready_i`.
- **Not defined:** the port is absent and codes can only be cut short by `rst_n`.

## Test plan
- K=0, bins "1" → `valid_o` with `value_o=0`, `bin_length_o=1`, `error_o=0`.
- K=0, bins "00111" → `value_o=6`, `bin_length_o=5`.
- K=2:
  - bins "101" → `value_o=1`, `bin_length_o=3`.
  - then bins "01101" → `value_o=9`, `bin_length_o=5`.
- K=0, "011" with `value_ready_i` held low 3 cycles → `valid_o`/`value_o=2` stable and `bin_ready_o=0` throughout. A bin toggling on `bin_i` is not consumed; the next code decodes correctly after release.
- VALUE_WIDTH=8, K=0, eight '0' bins → `valid_o=1`, `error_o=1`, `value_o=0`, `bin_length_o=8`. The following "1" decodes to 0.
- K=0, "0001" then 1 suffix bin, then `rst_n` low (or `abort_i` with `EGK_DEC_ABORT_EN`) → no `valid_o`. The subsequent "010" → `value_o=1`, `bin_length_o=3`.
